// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: FSM encoding and requester indices.
package data_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } arb_state_e;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_rr_pick.sv
// Two-way round-robin select: on a tie the side that did not win last time gets the grant.
module data_mem_arbiter_rr_pick
   import data_mem_arbiter_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_owner_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      if (req_i == 2'b11) begin
         if (last_owner_i == PORT1) gnt_o = 2'b01;
         else                       gnt_o = 2'b10;
      end else if (req_i[0]) begin
         gnt_o = 2'b01;
      end else if (req_i[1]) begin
         gnt_o = 2'b10;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data memory between P0 (core) and P1 (loader/debug) with
// round-robin, burst lock and a starvation guard; read data comes back registered.
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic        CLK,
   input  logic        rst,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic        p0_lock,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_gnt,
   output logic        p0_rvalid,
   output logic        p0_err,
   output logic [31:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic        p1_lock,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_gnt,
   output logic        p1_rvalid,
   output logic        p1_err,
   output logic [31:0] p1_rdata,
   output logic [31:0] mem_A,
   output logic [31:0] mem_WD,
   output logic        mem_WE,
   input  logic [31:0] mem_RD
);

   localparam int unsigned CntW   = $clog2(MAX_BURST + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);
   localparam logic [31:0]     DepthW = 32'(DEPTH);

   arb_state_e      state_q, state_d;
   logic            last_owner_q, last_owner_d;
   logic [CntW-1:0] burst_cnt_q, burst_cnt_d;

   logic [1:0]  req_v, lock_v, pick, gnt_raw, gnt;
   logic        owner, other, cont, win, any_gnt, sel_we, in_range;
   logic [31:0] sel_addr, sel_wdata;

   assign req_v  = {p1_req, p0_req};
   assign lock_v = {p1_lock, p0_lock};

   data_mem_arbiter_rr_pick u_rr_pick (
      .req_i        (req_v),
      .last_owner_i (last_owner_q),
      .gnt_o        (pick)
   );

   always_comb begin
      gnt_raw      = 2'b00;
      cont         = 1'b0;
      state_d      = state_q;
      last_owner_d = last_owner_q;
      burst_cnt_d  = burst_cnt_q;
      owner        = (state_q == ST_OWN1);
      other        = ~owner;
      win          = 1'b0;

      unique case (state_q)
         ST_IDLE: gnt_raw = pick;
         ST_OWN0, ST_OWN1: begin
            if (!req_v[owner]) begin
               gnt_raw = pick;
            end else if ((burst_cnt_q == CntMax) && req_v[other]) begin
               gnt_raw[other] = 1'b1;
            end else begin
               gnt_raw[owner] = 1'b1;
               cont           = 1'b1;
            end
         end
         default: gnt_raw = 2'b00;
      endcase

      if (gnt_raw != 2'b00) begin
         win          = gnt_raw[1];
         last_owner_d = win;
         if (cont) begin
            // Continuing owner: counter saturates so long uncontested bursts never wrap.
            if (burst_cnt_q != CntMax) burst_cnt_d = burst_cnt_q + 1'b1;
            state_d = lock_v[win] ? state_q : ST_IDLE;
         end else begin
            burst_cnt_d = CntW'(1);
            if (lock_v[win]) state_d = win ? ST_OWN1 : ST_OWN0;
            else             state_d = ST_IDLE;
         end
      end else begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_owner_q <= PORT1;
         burst_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
      end
   end

   // Reset suppresses every grant so no write can slip through in a reset cycle.
   assign gnt     = rst ? 2'b00 : gnt_raw;
   assign any_gnt = |gnt;
   assign p0_gnt  = gnt[0];
   assign p1_gnt  = gnt[1];

   assign sel_addr  = gnt[1] ? p1_addr  : p0_addr;
   assign sel_wdata = gnt[1] ? p1_wdata : p0_wdata;
   assign sel_we    = gnt[1] ? p1_we    : p0_we;
   assign in_range  = (sel_addr < DepthW);

   assign mem_A  = any_gnt ? sel_addr  : 32'd0;
   assign mem_WD = any_gnt ? sel_wdata : 32'd0;
   assign mem_WE = any_gnt & sel_we & in_range;

   logic        p0_rvalid_q, p0_err_q, p1_rvalid_q, p1_err_q;
   logic [31:0] p0_rdata_q, p1_rdata_q;
   logic        p0_rd_ok, p1_rd_ok;

   assign p0_rd_ok = gnt[0] & ~p0_we & in_range;
   assign p1_rd_ok = gnt[1] & ~p1_we & in_range;

   always_ff @(posedge CLK) begin
      if (rst) begin
         p0_rvalid_q <= 1'b0;
         p0_err_q    <= 1'b0;
         p0_rdata_q  <= 32'd0;
         p1_rvalid_q <= 1'b0;
         p1_err_q    <= 1'b0;
         p1_rdata_q  <= 32'd0;
      end else begin
         p0_rvalid_q <= p0_rd_ok;
         p0_err_q    <= gnt[0] & ~in_range;
         p1_rvalid_q <= p1_rd_ok;
         p1_err_q    <= gnt[1] & ~in_range;
         if (p0_rd_ok) p0_rdata_q <= mem_RD;
         if (p1_rd_ok) p1_rdata_q <= mem_RD;
      end
   end

   assign p0_rvalid = p0_rvalid_q;
   assign p0_err    = p0_err_q;
   assign p0_rdata  = p0_rdata_q;
   assign p1_rvalid = p1_rvalid_q;
   assign p1_err    = p1_err_q;
   assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural single-port memory behind it.
module tb_data_mem_arbiter;

   logic        CLK, rst;
   logic        p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid, p0_err;
   logic [31:0] p0_addr, p0_wdata, p0_rdata;
   logic        p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid, p1_err;
   logic [31:0] p1_addr, p1_wdata, p1_rdata;
   logic [31:0] mem_A, mem_WD, mem_RD;
   logic        mem_WE;

   int tests = 0;
   int fails = 0;

   logic [31:0] mem [0:1023];

   data_mem_arbiter dut (
      .CLK       (CLK),
      .rst       (rst),
      .p0_req    (p0_req),
      .p0_we     (p0_we),
      .p0_lock   (p0_lock),
      .p0_addr   (p0_addr),
      .p0_wdata  (p0_wdata),
      .p0_gnt    (p0_gnt),
      .p0_rvalid (p0_rvalid),
      .p0_err    (p0_err),
      .p0_rdata  (p0_rdata),
      .p1_req    (p1_req),
      .p1_we     (p1_we),
      .p1_lock   (p1_lock),
      .p1_addr   (p1_addr),
      .p1_wdata  (p1_wdata),
      .p1_gnt    (p1_gnt),
      .p1_rvalid (p1_rvalid),
      .p1_err    (p1_err),
      .p1_rdata  (p1_rdata),
      .mem_A     (mem_A),
      .mem_WD    (mem_WD),
      .mem_WE    (mem_WE),
      .mem_RD    (mem_RD)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Memory contents are a known pattern (A000_0000 + index) whenever reset is held.
   always @(posedge CLK) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      end else if (mem_WE) begin
         mem[mem_A[9:0]] <= mem_WD;
      end
   end
   assign mem_RD = mem[mem_A[9:0]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int          p1_n;
      logic        exp_p0;

      rst = 1'b1;
      p0_req = 1'b1; p0_we = 1'b1; p0_lock = 1'b0; p0_addr = 32'd5; p0_wdata = 32'h55;
      p1_req = 1'b1; p1_we = 1'b1; p1_lock = 1'b0; p1_addr = 32'd6; p1_wdata = 32'h66;

      // 1: reset with both requesting
      #1;
      check("rst_p0_gnt", 32'(p0_gnt), 32'd0);
      check("rst_p1_gnt", 32'(p1_gnt), 32'd0);
      check("rst_mem_we", 32'(mem_WE), 32'd0);
      tick();
      tick();
      check("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
      check("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
      check("rst_p0_err", 32'(p0_err), 32'd0);
      check("rst_p1_err", 32'(p1_err), 32'd0);
      check("rst_p0_rdata", p0_rdata, 32'd0);
      check("rst_mem_a", mem_A, 32'd0);

      // 3: continuous contention, no lock -> P0,P1,P0,P1
      rst = 1'b0;
      p0_we = 1'b0; p0_addr = 32'd3;
      p1_we = 1'b0; p1_addr = 32'd7;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("rr%0d_p0_gnt", i), 32'(p0_gnt), 32'(i % 2 == 0));
         check($sformatf("rr%0d_p1_gnt", i), 32'(p1_gnt), 32'(i % 2 == 1));
         tick();
         if (i % 2 == 0) begin
            check($sformatf("rr%0d_p0_rvalid", i), 32'(p0_rvalid), 32'd1);
            check($sformatf("rr%0d_p0_rdata", i), p0_rdata, 32'hA000_0003);
         end else begin
            check($sformatf("rr%0d_p1_rvalid", i), 32'(p1_rvalid), 32'd1);
            check($sformatf("rr%0d_p1_rdata", i), p1_rdata, 32'hA000_0007);
         end
      end
      p0_req = 1'b0; p1_req = 1'b0;
      tick();

      // 2: P0 write 28 then read it back
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'd28; p0_wdata = 32'h20;
      #1;
      check("wr_p0_gnt", 32'(p0_gnt), 32'd1);
      check("wr_mem_we", 32'(mem_WE), 32'd1);
      check("wr_mem_a", mem_A, 32'd28);
      tick();
      p0_we = 1'b0;
      #1;
      check("rd_p0_gnt", 32'(p0_gnt), 32'd1);
      check("wr_no_rvalid", 32'(p0_rvalid), 32'd0);
      tick();
      check("rd_p0_rvalid", 32'(p0_rvalid), 32'd1);
      check("rd_p0_rdata", p0_rdata, 32'h20);
      p0_req = 1'b0;
      tick();

      // 4: P1 locked burst over 40.., P0 gets in on the fifth grant
      p1_req = 1'b1; p1_lock = 1'b1; p1_we = 1'b0; p1_addr = 32'd40;
      p1_n = 0;
      for (int c = 0; c < 6; c++) begin
         if (c == 1) begin
            p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'd100; p0_lock = 1'b0;
         end
         #1;
         exp_p0 = (c == 4);
         check($sformatf("burst%0d_p0_gnt", c), 32'(p0_gnt), 32'(exp_p0));
         check($sformatf("burst%0d_p1_gnt", c), 32'(p1_gnt), 32'(!exp_p0));
         tick();
         if (exp_p0) begin
            check("burst_p0_rdata", p0_rdata, 32'hA000_0064);
            p0_req = 1'b0;
         end else begin
            check($sformatf("burst%0d_p1_rvalid", c), 32'(p1_rvalid), 32'd1);
            check($sformatf("burst%0d_p1_rdata", c), p1_rdata, 32'hA000_0028 + 32'(p1_n));
            p1_n++;
            p1_addr = 32'd40 + 32'(p1_n);
         end
      end

      // 6: reset mid-burst, right after a P1 read grant
      rst = 1'b1;
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'd60; p0_wdata = 32'hDEAD_BEEF;
      #1;
      check("rst6_p0_gnt", 32'(p0_gnt), 32'd0);
      check("rst6_p1_gnt", 32'(p1_gnt), 32'd0);
      check("rst6_mem_we", 32'(mem_WE), 32'd0);
      tick();
      rst = 1'b0;
      check("rst6_p1_rvalid", 32'(p1_rvalid), 32'd0);
      check("rst6_p1_rdata", p1_rdata, 32'd0);
      #1;
      check("post_rst_p0_gnt", 32'(p0_gnt), 32'd1);
      check("post_rst_p1_gnt", 32'(p1_gnt), 32'd0);
      check("post_rst_mem_we", 32'(mem_WE), 32'd1);
      tick();
      check("post_rst_mem60", mem[60], 32'hDEAD_BEEF);
      check("post_rst_p0_err", 32'(p0_err), 32'd0);
      p1_req = 1'b0; p1_lock = 1'b0;
      p0_we = 1'b0;
      tick();
      check("rd60_p0_rdata", p0_rdata, 32'hDEAD_BEEF);

      // 5: out of range read then write at DEPTH
      p0_addr = 32'd1024;
      #1;
      check("oor_rd_gnt", 32'(p0_gnt), 32'd1);
      tick();
      check("oor_rd_err", 32'(p0_err), 32'd1);
      check("oor_rd_rvalid", 32'(p0_rvalid), 32'd0);
      check("oor_rd_rdata_hold", p0_rdata, 32'hDEAD_BEEF);
      p0_we = 1'b1; p0_wdata = 32'h1234;
      #1;
      check("oor_wr_gnt", 32'(p0_gnt), 32'd1);
      check("oor_wr_mem_we", 32'(mem_WE), 32'd0);
      tick();
      p0_req = 1'b0;
      check("oor_wr_err", 32'(p0_err), 32'd1);
      check("oor_wr_rvalid", 32'(p0_rvalid), 32'd0);
      check("oor_wr_mem0", mem[0], 32'hA000_0000);
      tick();
      check("idle_p0_err", 32'(p0_err), 32'd0);
      check("idle_mem_a", mem_A, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
